// File: rtl/game_pkg.sv
// Shared types for the game-board cursor tracker: move directions, scan states
// and a width helper that keeps single-entry fields at least one bit wide.
package game_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_onehot_decode.sv
// Row index to one-hot row drive; indices at or beyond ROWS decode to all zeros.
module row_onehot_decode
  import game_pkg::*;
#(
  parameter int ROWS = 16
) (
  input  logic [width_of(ROWS)-1:0] i_row,
  output logic [ROWS-1:0]           o_onehot
);

  localparam int RW = width_of(ROWS);

  always_comb begin
    o_onehot = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (i_row == RW'(r)) o_onehot[r] = 1'b1;
    end
  end

endmodule

// File: rtl/led_cursor_scan.sv
// Multi-player cursor tracker: one move per cycle with wrap/saturate edges and
// collision rejection, plus a blanked time-multiplexed scan onto the LED matrix.
module led_cursor_scan
  import game_pkg::*;
#(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int CHANNELS = 2,
  parameter int DWELL    = 4,
  parameter int BLANK    = 1,
  parameter int WRAP     = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          move_valid,
  input  logic [width_of(CHANNELS)-1:0] move_ch,
  input  logic [1:0]                    move_dir,
  output logic                          move_done,
  output logic                          move_blocked,
  output logic [ROWS-1:0]               row_onehot,
  output logic [width_of(COLS)-1:0]     col_idx,
  output logic [width_of(CHANNELS)-1:0] scan_ch,
  output logic                          frame_start
);

  localparam int RW    = width_of(ROWS);
  localparam int CW    = width_of(COLS);
  localparam int CHW   = width_of(CHANNELS);
  localparam int CNT_W = width_of((DWELL > BLANK) ? DWELL : BLANK);

  logic [RW-1:0] r_row [CHANNELS];
  logic [CW-1:0] r_col [CHANNELS];
  logic          r_move_done, r_move_blocked;

  logic                w_ch_ok, w_off, w_accept;
  logic [CHW-1:0]      w_mv_idx;
  logic [RW-1:0]       w_cur_row, w_tgt_row;
  logic [CW-1:0]       w_cur_col, w_tgt_col;
  logic [CHANNELS-1:0] w_hit;

  // w_off marks an edge crossing; with WRAP the wrapped target is still used.
  always_comb begin
    w_ch_ok   = 32'(move_ch) < 32'(CHANNELS);
    w_mv_idx  = w_ch_ok ? move_ch : '0;
    w_cur_row = r_row[w_mv_idx];
    w_cur_col = r_col[w_mv_idx];
    w_tgt_row = w_cur_row;
    w_tgt_col = w_cur_col;
    w_off     = 1'b0;
    case (dir_t'(move_dir))
      DIR_UP: begin
        if (w_cur_row == '0) begin
          w_tgt_row = RW'(ROWS - 1);
          w_off     = 1'b1;
        end else w_tgt_row = w_cur_row - 1'b1;
      end
      DIR_DOWN: begin
        if (w_cur_row == RW'(ROWS - 1)) begin
          w_tgt_row = '0;
          w_off     = 1'b1;
        end else w_tgt_row = w_cur_row + 1'b1;
      end
      DIR_LEFT: begin
        if (w_cur_col == '0) begin
          w_tgt_col = CW'(COLS - 1);
          w_off     = 1'b1;
        end else w_tgt_col = w_cur_col - 1'b1;
      end
      DIR_RIGHT: begin
        if (w_cur_col == CW'(COLS - 1)) begin
          w_tgt_col = '0;
          w_off     = 1'b1;
        end else w_tgt_col = w_cur_col + 1'b1;
      end
    endcase
    w_accept = w_ch_ok && !(w_off && (WRAP == 0)) && (w_hit == '0);
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_hit
    assign w_hit[gi] = (32'(w_mv_idx) != gi) &&
                       (r_row[gi] == w_tgt_row) && (r_col[gi] == w_tgt_col);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_row[k] <= '0;
        r_col[k] <= CW'(k);
      end
      r_move_done    <= 1'b0;
      r_move_blocked <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (move_valid && w_accept && (32'(w_mv_idx) == k)) begin
          r_row[k] <= w_tgt_row;
          r_col[k] <= w_tgt_col;
        end
      end
      r_move_done    <= move_valid && w_accept;
      r_move_blocked <= move_valid && !w_accept;
    end
  end

  scan_state_t       r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [CHW-1:0]    r_scan_ch, w_scan_next;
  logic              w_advance;
  logic [ROWS-1:0]   r_row_onehot, w_row_dec, w_row_next;
  logic [CW-1:0]     r_col_idx, w_col_next;
  logic              r_frame_start, w_frame_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= game_pkg::SHOW;
      r_cnt         <= '0;
      r_scan_ch     <= '0;
      r_row_onehot  <= ROWS'(1);
      r_col_idx     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_scan_ch     <= w_scan_next;
      r_row_onehot  <= w_row_next;
      r_col_idx     <= w_col_next;
      r_frame_start <= w_frame_next;
    end
  end

  // The dwell counter is reused to time the blank gap.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_scan_next  = r_scan_ch;
    w_advance    = 1'b0;
    case (r_state)
      game_pkg::SHOW: begin
        if (r_cnt == CNT_W'(DWELL - 1)) begin
          w_cnt_next = '0;
          if (BLANK == 0) w_advance = 1'b1;
          else            w_state_next = game_pkg::BLANK;
        end
      end
      game_pkg::BLANK: begin
        if (r_cnt == CNT_W'(BLANK - 1)) begin
          w_cnt_next   = '0;
          w_advance    = 1'b1;
          w_state_next = game_pkg::SHOW;
        end
      end
    endcase
    if (w_advance)
      w_scan_next = (r_scan_ch == CHW'(CHANNELS - 1)) ? '0 : r_scan_ch + 1'b1;
  end

  row_onehot_decode #(.ROWS(ROWS)) u_row_decode (
    .i_row    (r_row[w_scan_next]),
    .o_onehot (w_row_dec)
  );

  always_comb begin
    w_row_next   = (w_state_next == game_pkg::SHOW) ? w_row_dec : '0;
    w_col_next   = r_col[w_scan_next];
    w_frame_next = w_advance && (w_scan_next == '0);
  end

  assign move_done    = r_move_done;
  assign move_blocked = r_move_blocked;
  assign row_onehot   = r_row_onehot;
  assign col_idx      = r_col_idx;
  assign scan_ch      = r_scan_ch;
  assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_led_cursor_scan.sv
// Scoreboard bench for led_cursor_scan over three parameter sets, checked
// against a board/timing model built from plain positions and slot arithmetic.
module tb_led_cursor_scan;

  localparam int NI = 3;
  localparam int PR[NI] = '{16, 12, 10};
  localparam int PC[NI] = '{16, 10, 6};
  localparam int PN[NI] = '{2, 3, 3};
  localparam int PD[NI] = '{4, 3, 2};
  localparam int PB[NI] = '{1, 2, 0};
  localparam int PW[NI] = '{1, 0, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mv = 1'b0;
  logic [1:0] mch = 2'd0;
  logic [1:0] mdir = 2'd0;

  always #5 clk = ~clk;

  logic [15:0] oh_a;
  logic [11:0] oh_b;
  logic [9:0]  oh_c;
  logic [3:0]  col_a, col_b;
  logic [2:0]  col_c;
  logic        sch_a;
  logic [1:0]  sch_b, sch_c;
  logic [2:0]  fs, dn, bk;

  logic [15:0] oh [NI];
  logic [3:0]  col [NI];
  logic [1:0]  sch [NI];

  always_comb begin
    oh[0]  = oh_a;          oh[1]  = {4'b0, oh_b};  oh[2]  = {6'b0, oh_c};
    col[0] = col_a;         col[1] = col_b;         col[2] = {1'b0, col_c};
    sch[0] = {1'b0, sch_a}; sch[1] = sch_b;         sch[2] = sch_c;
  end

  led_cursor_scan #(.ROWS(16), .COLS(16), .CHANNELS(2), .DWELL(4), .BLANK(1), .WRAP(1)) dut_a (
    .clk(clk), .reset(reset), .move_valid(mv), .move_ch(mch[0:0]), .move_dir(mdir),
    .move_done(dn[0]), .move_blocked(bk[0]), .row_onehot(oh_a), .col_idx(col_a),
    .scan_ch(sch_a), .frame_start(fs[0]));

  led_cursor_scan #(.ROWS(12), .COLS(10), .CHANNELS(3), .DWELL(3), .BLANK(2), .WRAP(0)) dut_b (
    .clk(clk), .reset(reset), .move_valid(mv), .move_ch(mch), .move_dir(mdir),
    .move_done(dn[1]), .move_blocked(bk[1]), .row_onehot(oh_b), .col_idx(col_b),
    .scan_ch(sch_b), .frame_start(fs[1]));

  led_cursor_scan #(.ROWS(10), .COLS(6), .CHANNELS(3), .DWELL(2), .BLANK(0), .WRAP(1)) dut_c (
    .clk(clk), .reset(reset), .move_valid(mv), .move_ch(mch), .move_dir(mdir),
    .move_done(dn[2]), .move_blocked(bk[2]), .row_onehot(oh_c), .col_idx(col_c),
    .scan_ch(sch_c), .frame_start(fs[2]));

  typedef struct packed {
    logic [15:0] row;
    logic [3:0]  col;
    logic [1:0]  ch;
    logic        show;
    logic        fs;
  } exp_t;
  typedef exp_t [NI-1:0] exp3_t;

  int    mrow [NI][3];
  int    mcol [NI][3];
  int    tcur;
  exp3_t dq[$];
  int    pq [NI][$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input int i, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // Display expected in cycle u since reset, given the positions it should show.
  function automatic exp_t expect_at(input int i, input int u);
    exp_t e;
    int sl = PD[i] + PB[i];
    int s  = u % (PN[i] * sl);
    int ch = s / sl;
    e.ch   = 2'(ch);
    e.show = (s % sl) < PD[i];
    e.fs   = (u > 0) && (s == 0);
    e.row  = e.show ? (16'(1) << mrow[i][ch]) : 16'h0;
    e.col  = 4'(mcol[i][ch]);
    return e;
  endfunction

  // Returns 1 for an applied move, 2 for a rejected one; updates the board.
  function automatic int try_move(input int i, input int ch, input int dir);
    int r, c;
    if (ch >= PN[i]) return 2;
    r = mrow[i][ch];
    c = mcol[i][ch];
    case (dir)
      0:       r = r - 1;
      1:       r = r + 1;
      2:       c = c - 1;
      default: c = c + 1;
    endcase
    if (PW[i] != 0) begin
      r = (r + PR[i]) % PR[i];
      c = (c + PC[i]) % PC[i];
    end else if (r < 0 || r >= PR[i] || c < 0 || c >= PC[i]) begin
      return 2;
    end
    for (int k = 0; k < PN[i]; k++)
      if (k != ch && mrow[i][k] == r && mcol[i][k] == c) return 2;
    mrow[i][ch] = r;
    mcol[i][ch] = c;
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < 3; k++) begin
        mrow[i][k] = 0;
        mcol[i][k] = k;
      end
    tcur = 0;
  endtask

  task automatic do_cycle(input bit rst, input bit v, input int ch, input int dir);
    exp3_t e;
    int    kind [NI];
    reset = rst;
    mv    = v;
    mch   = 2'(ch);
    mdir  = 2'(dir);
    for (int i = 0; i < NI; i++) kind[i] = 0;
    if (rst) begin
      model_reset();
      for (int i = 0; i < NI; i++) e[i] = expect_at(i, 0);
    end else begin
      for (int i = 0; i < NI; i++) e[i] = expect_at(i, tcur + 1);
      if (v)
        for (int i = 0; i < NI; i++) kind[i] = try_move(i, (i == 0) ? (ch % 2) : ch, dir);
      tcur++;
    end
    @(posedge clk);
    dq.push_back(e);
    for (int i = 0; i < NI; i++) if (kind[i] != 0) pq[i].push_back(kind[i]);
    #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) do_cycle(1'b0, 1'b0, 0, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp3_t e;
    int    act;
    if (dq.size() > 0) begin
      e = dq.pop_front();
      for (int i = 0; i < NI; i++) begin
        check("row_onehot", i, oh[i], e[i].row);
        if (e[i].show) check("col_idx", i, col[i], e[i].col);
        check("scan_ch", i, sch[i], e[i].ch);
        check("frame_start", i, fs[i], e[i].fs);
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (dn[i] || bk[i]) begin
        act = (dn[i] ? 1 : 0) + (bk[i] ? 2 : 0);
        if (pq[i].size() == 0) check("pulse_unexpected", i, act, 0);
        else                   check("move_pulse", i, act, pq[i].pop_front());
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) do_cycle(1'b1, 1'b0, 0, 0);
    idle(22);
    do_cycle(1'b0, 1'b1, 1, 2);   // ch1 left into ch0: collision
    do_cycle(1'b0, 1'b1, 1, 1);   // ch1 down
    do_cycle(1'b0, 1'b1, 1, 2);   // ch1 left to (1,0)
    idle(12);
    do_cycle(1'b0, 1'b1, 0, 0);   // ch0 up from row 0: wrap or reject
    idle(12);
    do_cycle(1'b0, 1'b1, 0, 2);   // ch0 left from col 0
    idle(12);
    do_cycle(1'b0, 1'b1, 3, 1);   // channel out of range on 3-channel boards
    do_cycle(1'b0, 1'b1, 2, 3);
    do_cycle(1'b0, 1'b1, 2, 1);
    do_cycle(1'b0, 1'b1, 0, 1);
    do_cycle(1'b0, 1'b1, 0, 3);
    do_cycle(1'b1, 1'b1, 0, 1);   // reset wins over a move
    idle(12);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0)
        do_cycle(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        do_cycle(1'b0, $urandom_range(0, 9) < 7, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    idle(4);
    @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) check("pending_pulses", i, pq[i].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_cursor_scan.md
Name: led_cursor_scan

Overview:
- Multi-player cursor tracker and LED-matrix scan driver for the game board.
- Holds one (row, col) position per channel (player) and accepts one move command per cycle, with an edge policy (wrap or saturate) and a collision check.
- Time-multiplexes all channels onto a single one-hot row bus plus column index for the matrix driver.
- Blanks the row bus between channel slots to stop ghosting.

Parameters:
- ROWS, 16: matrix rows; row_onehot width.
- COLS, 16: matrix columns.
- CHANNELS, 2: number of cursors. Must satisfy 1 <= CHANNELS <= COLS.
- DWELL, 4: cycles each channel is shown per slot. Must be >= 1.
- BLANK, 1: blank cycles after each slot. 0 removes the BLANK state.
- WRAP, 1: 1 = modular wrap at board edges; 0 = saturate and reject the move.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- move_valid  in  1  move request this cycle.
- move_ch  in  max(1,$clog2(CHANNELS))  channel to move.
- move_dir  in  2  direction: 00 up (row-1), 01 down (row+1), 10 left (col-1), 11 right (col+1).
- move_done  out  1  one-cycle pulse: previous-cycle move applied.
- move_blocked  out  1  one-cycle pulse: previous-cycle move rejected.
- row_onehot  out  ROWS  one-hot row drive; all zeros while blanking.
- col_idx  out  $clog2(COLS)  column of the displayed cursor.
- scan_ch  out  max(1,$clog2(CHANNELS))  channel currently displayed.
- frame_start  out  1  one-cycle pulse on entry to channel 0's SHOW slot.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset); it overrides all other inputs in the same cycle.
- Reset state:
  - Channel k position = (row 0, col k).
  - FSM = SHOW, dwell counter = 0, scan_ch = 0.
  - row_onehot = 1 (row 0), col_idx = 0.
  - move_done = 0, move_blocked = 0, frame_start = 0.
- Scan FSM has two states, SHOW and BLANK.
  - SHOW: the dwell counter counts 0..DWELL-1. At DWELL-1 the FSM goes to BLANK, or, if BLANK = 0, advances scan_ch and stays in SHOW.
  - BLANK: lasts BLANK cycles with row_onehot = 0. It then advances scan_ch (CHANNELS-1 wraps to 0) and returns to SHOW.
  - frame_start is registered and high in the first SHOW cycle of channel 0 after a wrap. It is not asserted in the first cycle after reset.
- Display path:
  - row_onehot and col_idx are registered. In SHOW they show the decoded position register of scan_ch as of the previous cycle.
  - A move applied at edge N is therefore visible at edge N+1, if that channel is in SHOW.
- Move evaluation:
  - At most one move per cycle. It is evaluated against the current position registers, and the result is committed at the next edge.
  - Target is computed per move_dir.
    - WRAP = 1: row arithmetic is modulo ROWS and column arithmetic modulo COLS (0-1 becomes max; max+1 becomes 0).
    - WRAP = 0: a target off the board is rejected.
  - A move is rejected if move_ch >= CHANNELS.
  - A move is rejected if the target equals any other channel's current position.
  - Accepted: position updates, and move_done = 1 in the next cycle.
  - Rejected: position is unchanged, and move_blocked = 1 in the next cycle.
  - The two pulses are mutually exclusive and each lasts exactly one cycle.
- Moves do not stall the scan, and the scan does not stall moves (always ready).
- Reset during a move: the move is discarded, no pulse is produced, and positions return to their reset values.
- Width rules: position registers are $clog2(ROWS) and $clog2(COLS) bits. Non-power-of-2 ROWS/COLS wrap at ROWS-1 and COLS-1, not at 2^n-1.

Decomposition:
- Package game_pkg:
  - dir_t enum: DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11.
  - scan_state_t enum: SHOW, BLANK.
- Sub-module row_onehot_decode #(ROWS): combinational row index to one-hot, instantiated once on the display path. Out-of-range index gives all zeros.

Test Plan:
- Defaults, reset released, no moves:
  - row_onehot=16'h0001, col_idx=0, scan_ch=0 for 4 cycles, then 16'h0000 for 1 cycle.
  - Then 16'h0001, col_idx=1, scan_ch=1 for 4 cycles, blank for 1 cycle.
  - Then frame_start=1 with scan_ch=0; period is 10 cycles.
- WRAP=1: ch0 DIR_UP from (0,0) -> move_done next cycle; the next ch0 slot shows row_onehot=16'h8000, col_idx=0.
- WRAP=0 instance: ch0 DIR_LEFT at (0,0) -> move_blocked next cycle; ch0 still shows 16'h0001, col 0.
- Collision:
  - ch1 DIR_LEFT from (0,1) toward ch0 at (0,0) -> move_blocked.
  - ch1 DIR_DOWN -> move_done, ch1 now at (1,0... i.e. row 1, col 1).
  - ch1 DIR_LEFT -> move_done; ch1 shows 16'h0002, col_idx=0.
- CHANNELS=3 instance: move_ch=3 -> move_blocked, no position changes.
- reset=1 in the same cycle as move_valid, with ch0 moved beforehand to (5,5):
  - No pulse next cycle.
  - ch0 shows 16'h0001, col 0.
  - FSM restarts in SHOW with scan_ch=0.
